encdec_apb_driver: RTL and testbench



---
 rtl/encdec_apb_driver.sv | 272 +++++++++++++++++++++++++++
 tb/tb_encdec_apb_driver.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encdec_apb_driver.sv
// ============================================================================
//  Module   : encdec_apb_driver
//  Purpose  : APB write initiator that turns one EncDec job request into the
//             CODEWORD_WIDTH/DATA_IN/NOISE/CTRL write sequence, waits for
//             operation_done and returns the result on a valid/ready port.
//             Optional macro ENCDEC_DRV_SKIP_EN drops CODEWORD_WIDTH/NOISE
//             writes that match the last value written since reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module encdec_apb_driver #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_mode,
    input  logic [1:0]                 req_width,
    input  logic [AMBA_WORD-1:0]       req_data,
    input  logic [AMBA_WORD-1:0]       req_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       done_i,
    input  logic [DATA_WIDTH-1:0]      data_i,
    input  logic [1:0]                 nerr_i,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_WIDTH-1:0]      res_data,
    output logic [1:0]                 res_nerr,
    output logic [1:0]                 res_status
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Write-list slots, issued in ascending order; CTRL must stay last.
    localparam logic [1:0] SLOT_WIDTH = 2'd0;
    localparam logic [1:0] SLOT_DATA  = 2'd1;
    localparam logic [1:0] SLOT_NOISE = 2'd2;
    localparam logic [1:0] SLOT_CTRL  = 2'd3;

    localparam logic [1:0] MODE_FULL    = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
    localparam logic [1:0] STATUS_ILLEGAL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_ACCESS    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              slot_q, slot_d;
    logic                    wr_noise_q, wr_noise_d;
    logic [1:0]              mode_q, mode_d;
    logic [1:0]              width_q, width_d;
    logic [AMBA_WORD-1:0]    data_q, data_d;
    logic [AMBA_WORD-1:0]    noise_q, noise_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   res_data_q, res_data_d;
    logic [1:0]              res_nerr_q, res_nerr_d;
    logic [1:0]              res_status_q, res_status_d;

    logic                    w_skip_width;
    logic                    w_need_noise;
    logic [3:0]              w_addr;
    logic [AMBA_WORD-1:0]    w_wdata;

`ifdef ENCDEC_DRV_SKIP_EN
    logic [1:0]              sh_width_q, sh_width_d;
    logic                    sh_width_vld_q, sh_width_vld_d;
    logic [AMBA_WORD-1:0]    sh_noise_q, sh_noise_d;
    logic                    sh_noise_vld_q, sh_noise_vld_d;

    assign w_skip_width = sh_width_vld_q && (sh_width_q == req_width);
    assign w_need_noise = (req_mode == MODE_FULL) &&
                          !(sh_noise_vld_q && (sh_noise_q == req_noise));
`else
    assign w_skip_width = 1'b0;
    assign w_need_noise = (req_mode == MODE_FULL);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            slot_q       <= SLOT_WIDTH;
            wr_noise_q   <= 1'b0;
            mode_q       <= '0;
            width_q      <= '0;
            data_q       <= '0;
            noise_q      <= '0;
            cnt_q        <= '0;
            res_data_q   <= '0;
            res_nerr_q   <= '0;
            res_status_q <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            wr_noise_q   <= wr_noise_d;
            mode_q       <= mode_d;
            width_q      <= width_d;
            data_q       <= data_d;
            noise_q      <= noise_d;
            cnt_q        <= cnt_d;
            res_data_q   <= res_data_d;
            res_nerr_q   <= res_nerr_d;
            res_status_q <= res_status_d;
        end
    end

`ifdef ENCDEC_DRV_SKIP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_width_q     <= '0;
            sh_width_vld_q <= 1'b0;
            sh_noise_q     <= '0;
            sh_noise_vld_q <= 1'b0;
        end else begin
            sh_width_q     <= sh_width_d;
            sh_width_vld_q <= sh_width_vld_d;
            sh_noise_q     <= sh_noise_d;
            sh_noise_vld_q <= sh_noise_vld_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        wr_noise_d   = wr_noise_q;
        mode_d       = mode_q;
        width_d      = width_q;
        data_d       = data_q;
        noise_d      = noise_q;
        cnt_d        = cnt_q;
        res_data_d   = res_data_q;
        res_nerr_d   = res_nerr_q;
        res_status_d = res_status_q;
`ifdef ENCDEC_DRV_SKIP_EN
        sh_width_d     = sh_width_q;
        sh_width_vld_d = sh_width_vld_q;
        sh_noise_d     = sh_noise_q;
        sh_noise_vld_d = sh_noise_vld_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    mode_d  = req_mode;
                    width_d = req_width;
                    data_d  = req_data;
                    noise_d = req_noise;
                    if (req_mode == MODE_ILLEGAL) begin
                        res_status_d = STATUS_ILLEGAL;
                        res_data_d   = '0;
                        res_nerr_d   = '0;
                        state_d      = ST_RESP;
                    end else begin
                        wr_noise_d = w_need_noise;
                        slot_d     = w_skip_width ? SLOT_DATA : SLOT_WIDTH;
                        state_d    = ST_SETUP;
                    end
                end
            end

            ST_SETUP: begin
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
`ifdef ENCDEC_DRV_SKIP_EN
                if (slot_q == SLOT_WIDTH) begin
                    sh_width_d     = width_q;
                    sh_width_vld_d = 1'b1;
                end
                if (slot_q == SLOT_NOISE) begin
                    sh_noise_d     = noise_q;
                    sh_noise_vld_d = 1'b1;
                end
`endif
                if (slot_q == SLOT_CTRL) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_DONE;
                end else begin
                    // DATA_IN is followed by NOISE only when the job needs it.
                    if (slot_q == SLOT_DATA && !wr_noise_q) begin
                        slot_d = SLOT_CTRL;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                    state_d = ST_SETUP;
                end
            end

            ST_WAIT_DONE: begin
                if (done_i) begin
                    res_data_d   = data_i;
                    res_nerr_d   = nerr_i;
                    res_status_d = STATUS_OK;
                    state_d      = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_data_d   = '0;
                    res_nerr_d   = '0;
                    res_status_d = STATUS_TIMEOUT;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_addr  = 4'h0;
        w_wdata = '0;
        case (slot_q)
            SLOT_WIDTH: begin
                w_addr  = 4'h8;
                w_wdata = {{(AMBA_WORD-2){1'b0}}, width_q};
            end
            SLOT_DATA: begin
                w_addr  = 4'h4;
                w_wdata = data_q;
            end
            SLOT_NOISE: begin
                w_addr  = 4'hC;
                w_wdata = noise_q;
            end
            default: begin
                w_addr  = 4'h0;
                w_wdata = {{(AMBA_WORD-2){1'b0}}, mode_q};
            end
        endcase
    end

    assign PSEL       = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE    = (state_q == ST_ACCESS);
    assign PWRITE     = PSEL;
    assign PADDR      = PSEL ? {{(AMBA_ADDR_WIDTH-4){1'b0}}, w_addr} : '0;
    assign PWDATA     = PSEL ? w_wdata : '0;
    assign req_ready  = (state_q == ST_IDLE);
    assign res_valid  = (state_q == ST_RESP);
    assign res_data   = res_data_q;
    assign res_nerr   = res_nerr_q;
    assign res_status = res_status_q;

endmodule

`default_nettype wire

// File: tb/tb_encdec_apb_driver.sv
// ============================================================================
//  Module   : tb_encdec_apb_driver
//  Purpose  : Directed self-checking bench for encdec_apb_driver; honours
//             ENCDEC_DRV_SKIP_EN when computing expected write lists.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_encdec_apb_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_mode;
    logic [1:0]  req_width;
    logic [31:0] req_data;
    logic [31:0] req_noise;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic        done_i;
    logic [31:0] data_i;
    logic [1:0]  nerr_i;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_nerr;
    logic [1:0]  res_status;

    encdec_apb_driver #(
        .DATA_WIDTH      (32),
        .AMBA_ADDR_WIDTH (20),
        .AMBA_WORD       (32),
        .TIMEOUT_CYCLES  (64)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mode   (req_mode),
        .req_width  (req_width),
        .req_data   (req_data),
        .req_noise  (req_noise),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .done_i     (done_i),
        .data_i     (data_i),
        .nerr_i     (nerr_i),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_nerr   (res_nerr),
        .res_status (res_status)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // APB write log: address, data and the clock edge ending each ACCESS.
    logic [19:0] wa [0:31];
    logic [31:0] wd [0:31];
    int          we [0:31];
    int          wr_cnt     = 0;
    logic        pwrite_bad = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (PSEL && !PWRITE) pwrite_bad = 1'b1;
        if (PSEL && PENABLE && wr_cnt < 32) begin
            wa[wr_cnt] = PADDR;
            wd[wr_cnt] = PWDATA;
            we[wr_cnt] = cyc + 1;
            wr_cnt     = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [1:0] m, input logic [1:0] w,
                             input logic [31:0] d, input logic [31:0] nz,
                             output int n_edge);
        @(negedge clk);
        check("req_ready_before_job", {63'b0, req_ready}, 64'd1);
        req_mode  = m;
        req_width = w;
        req_data  = d;
        req_noise = nz;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        n_edge    = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k;
        k = 0;
        while (wr_cnt < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (wr_cnt < n) check("write_wait_expired", 64'(wr_cnt), 64'(n));
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [19:0] a, input logic [31:0] d);
        check({tag, "_addr"}, {44'b0, wa[idx]}, {44'b0, a});
        check({tag, "_data"}, {32'b0, wd[idx]}, {32'b0, d});
    endtask

    task automatic pulse_done(input int dly, input logic [31:0] d, input logic [1:0] ne);
        repeat (dly) @(posedge clk);
        #1;
        done_i = 1'b1;
        data_i = d;
        nerr_i = ne;
        @(negedge clk);
        check("res_valid_low_at_done", {63'b0, res_valid}, 64'd0);
        @(posedge clk);
        #1;
        done_i = 1'b0;
        data_i = 32'h0;
        nerr_i = 2'd0;
        @(negedge clk);
        check("res_valid_after_done", {63'b0, res_valid}, 64'd1);
    endtask

    task automatic accept_result();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("idle_after_accept_ready", {63'b0, req_ready}, 64'd1);
        check("idle_after_accept_valid", {63'b0, res_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n_edge;
        int   base;
        int   k;
        logic stable_bad;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_mode  = 2'd0;
        req_width = 2'd0;
        req_data  = 32'h0;
        req_noise = 32'h0;
        done_i    = 1'b0;
        data_i    = 32'h0;
        nerr_i    = 2'd0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);

        // Reset values
        check("rst_psel",    {63'b0, PSEL},       64'd0);
        check("rst_penable", {63'b0, PENABLE},    64'd0);
        check("rst_pwrite",  {63'b0, PWRITE},     64'd0);
        check("rst_paddr",   {44'b0, PADDR},      64'd0);
        check("rst_pwdata",  {32'b0, PWDATA},     64'd0);
        check("rst_res_vld", {63'b0, res_valid},  64'd0);
        check("rst_res_dat", {32'b0, res_data},   64'd0);
        check("rst_res_ne",  {62'b0, res_nerr},   64'd0);
        check("rst_res_st",  {62'b0, res_status}, 64'd0);
        check("rst_req_rdy", {63'b0, req_ready},  64'd1);

        // Encode, width small, data 0x5
        base = wr_cnt;
        start_job(2'b00, 2'b00, 32'h5, 32'h0, n_edge);
        wait_writes(base + 3, 20);
        check("enc_nwr", 64'(wr_cnt - base), 64'd3);
        check_write("enc_w0", base + 0, 20'h8, 32'h0);
        check_write("enc_w1", base + 1, 20'h4, 32'h5);
        check_write("enc_w2", base + 2, 20'h0, 32'h0);
        check("enc_ctrl_end", 64'(we[base + 2] - n_edge), 64'd6);
        pulse_done(3, 32'hCAFE0005, 2'd0);
        check("enc_status", {62'b0, res_status}, 64'd0);
        check("enc_data",   {32'b0, res_data},   64'hCAFE0005);
        check("enc_nerr",   {62'b0, res_nerr},   64'd0);

        // Result held while res_ready stays low
        stable_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== 32'hCAFE0005 ||
                res_status !== 2'b00 || req_ready !== 1'b0) stable_bad = 1'b1;
        end
        check("hold_stable", {63'b0, stable_bad}, 64'd0);
        accept_result();

        // Full channel, width large, noise 3
        base = wr_cnt;
        start_job(2'b10, 2'b10, 32'h1234, 32'h3, n_edge);
        wait_writes(base + 4, 20);
        check("full_nwr", 64'(wr_cnt - base), 64'd4);
        check_write("full_w0", base + 0, 20'h8, 32'h2);
        check_write("full_w1", base + 1, 20'h4, 32'h1234);
        check_write("full_w2", base + 2, 20'hC, 32'h3);
        check_write("full_w3", base + 3, 20'h0, 32'h2);
        check("full_ctrl_end", 64'(we[base + 3] - n_edge), 64'd8);
        pulse_done(1, 32'h0000A5A5, 2'd2);
        check("full_nerr",   {62'b0, res_nerr},   64'd2);
        check("full_data",   {32'b0, res_data},   64'hA5A5);
        check("full_status", {62'b0, res_status}, 64'd0);
        accept_result();

        // Identical full-channel job again
        base = wr_cnt;
        start_job(2'b10, 2'b10, 32'h1234, 32'h3, n_edge);
`ifdef ENCDEC_DRV_SKIP_EN
        wait_writes(base + 2, 20);
        check("rep_nwr", 64'(wr_cnt - base), 64'd2);
        check_write("rep_w0", base + 0, 20'h4, 32'h1234);
        check_write("rep_w1", base + 1, 20'h0, 32'h2);
        check("rep_ctrl_end", 64'(we[base + 1] - n_edge), 64'd4);
`else
        wait_writes(base + 4, 20);
        check("rep_nwr", 64'(wr_cnt - base), 64'd4);
        check_write("rep_w0", base + 0, 20'h8, 32'h2);
        check_write("rep_w2", base + 2, 20'hC, 32'h3);
        check("rep_ctrl_end", 64'(we[base + 3] - n_edge), 64'd8);
`endif
        pulse_done(0, 32'h11112222, 2'd1);
        check("rep_nerr", {62'b0, res_nerr}, 64'd1);
        accept_result();

        // Illegal mode: immediate response, no APB traffic
        base = wr_cnt;
        start_job(2'b11, 2'b01, 32'h99, 32'h0, n_edge);
        @(negedge clk);
        check("ill_valid",  {63'b0, res_valid},  64'd1);
        check("ill_status", {62'b0, res_status}, 64'd2);
        check("ill_edge",   64'(cyc - n_edge),   64'd0);
        check("ill_psel",   {63'b0, PSEL},       64'd0);
        accept_result();
        check("ill_nwr", 64'(wr_cnt - base), 64'd0);

        // Timeout: done_i never asserted
        base = wr_cnt;
        start_job(2'b01, 2'b01, 32'h7, 32'h0, n_edge);
        wait_writes(base + 3, 20);
        check("to_ctrl_end", 64'(we[base + 2] - n_edge), 64'd6);
        k = 0;
        while (res_valid !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("to_rise_cycle", 64'(cyc - n_edge), 64'd70);
        check("to_status",     {62'b0, res_status}, 64'd1);
        check("to_data",       {32'b0, res_data},   64'd0);
        check("to_nerr",       {62'b0, res_nerr},   64'd0);
        accept_result();

        // Reset during the DATA_IN ACCESS cycle
        start_job(2'b00, 2'b10, 32'h55, 32'h0, n_edge);
        k = 0;
        while (!(PSEL === 1'b1 && PENABLE === 1'b1 && PADDR === 20'h4) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_found", {63'b0, PENABLE}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = wr_cnt;
        @(negedge clk);
        check("rst_mid_psel",    {63'b0, PSEL},      64'd0);
        check("rst_mid_penable", {63'b0, PENABLE},   64'd0);
        check("rst_mid_ready",   {63'b0, req_ready}, 64'd1);
        repeat (10) @(negedge clk);
        check("rst_mid_nowr", 64'(wr_cnt - base), 64'd0);

        check("pwrite_follows_psel", {63'b0, pwrite_bad}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
